if_fetch_gen: RTL and testbench

- Parametrised next-generation fetch-address generator for the front end; successor to the fixed 2-wide, always-ready IF stage.
- Issues fetch-block requests over an SRAM-like request/address-ok/data-ok interface, with up to MAX_OUT requests in flight.
- Applies branch redirects (execute) and predictor redirects (decode), each captured while it cannot be taken yet. Tags every request with a slot-valid mask, and drops responses made stale by a redirect before they reach decode.

---
 rtl/if_fetch_gen_if.sv | 26 ++
 rtl/if_fetch_gen.sv | 168 ++++++++++++++++
 tb/tb_if_fetch_gen.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_gen_if.sv
// SRAM-like instruction fetch bus: request/address-ok handshake and in-order data-ok responses.
interface if_fetch_gen_if #(
    parameter int FETCH_W = 2
) ();
    logic                   inst_req;
    logic [31:0]            inst_addr;
    logic                   inst_addr_ok;
    logic                   inst_data_ok;
    logic [32*FETCH_W-1:0]  inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );
endinterface

// File: rtl/if_fetch_gen.sv
// Fetch-address generator: issues block requests, applies branch/predictor redirects and
// drops responses that a redirect has made stale before they reach decode.
module if_fetch_gen #(
    parameter int          FETCH_W  = 2,
    parameter logic [31:0] RESET_PC = 32'hbfbf_fff8,
    parameter int          MAX_OUT  = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  stall,
    input  logic [32:0]           br_bus,
    input  logic [32:0]           bp_bus,
    if_fetch_gen_if.master        inst,
    output logic                  resp_valid,
    output logic [31:0]           resp_pc,
    output logic [FETCH_W-1:0]    resp_mask,
    output logic [32*FETCH_W-1:0] resp_inst
);
    localparam int          BLK_BYTES  = FETCH_W * 4;
    localparam int          PTR_W      = $clog2(MAX_OUT);
    localparam int          CNT_W      = PTR_W + 1;
    localparam logic [31:0] ALIGN_MASK = ~(32'(BLK_BYTES) - 32'd1);

    // Slots before the target's word offset inside the block are not to be executed.
    function automatic logic [FETCH_W-1:0] slot_mask(input logic [31:0] target);
        logic [31:0]        slot;
        logic [FETCH_W-1:0] m;
        slot = (target >> 2) & 32'(FETCH_W - 1);
        for (int i = 0; i < FETCH_W; i++) m[i] = (32'(i) >= slot);
        return m;
    endfunction

    typedef struct packed {
        logic [31:0]        pc;
        logic [FETCH_W-1:0] mask;
        logic               stale;
    } tag_t;

    logic               req_en_q, req_en_d;
    logic [31:0]        pc_q, pc_d;
    logic [FETCH_W-1:0] mask_q, mask_d;
    logic               br_held_q, br_held_d;
    logic [31:0]        br_addr_q, br_addr_d;
    logic               bp_held_q, bp_held_d;
    logic [31:0]        bp_addr_q, bp_addr_d;
    tag_t               fifo_q [MAX_OUT];
    tag_t               fifo_d [MAX_OUT];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic        br_e, bp_e, bp_take, redirect;
    logic [31:0] br_tgt, bp_tgt;
    logic        fifo_full, fifo_empty;
    logic        inst_req, fire, pop;
    logic        jump;
    logic [31:0] jump_tgt;
    tag_t        head;

    assign br_e   = br_bus[32];
    assign br_tgt = br_bus[31:0];
    assign bp_e   = bp_bus[32];
    assign bp_tgt = bp_bus[31:0];

    // A predictor redirect loses to any branch redirect, live or held.
    assign bp_take  = bp_e & ~br_e & ~br_held_q;
    assign redirect = br_e | bp_take | br_held_q | bp_held_q;

    assign fifo_full  = (count_q == CNT_W'(MAX_OUT));
    assign fifo_empty = (count_q == '0);

    assign inst_req       = req_en_q & ~stall & ~fifo_full;
    assign inst.inst_req  = inst_req;
    assign inst.inst_addr = pc_q;
    assign fire           = inst_req & inst.inst_addr_ok;
    assign pop            = inst.inst_data_ok & ~fifo_empty;

    assign head       = fifo_q[rd_ptr_q];
    assign resp_valid = inst.inst_data_ok & ~fifo_empty & ~head.stale & ~redirect;
    assign resp_pc    = resp_valid ? head.pc : '0;
    assign resp_mask  = resp_valid ? head.mask : '0;
    assign resp_inst  = inst.inst_rdata;

    always_comb begin
        jump     = 1'b1;
        jump_tgt = '0;
        if (br_held_q)      jump_tgt = br_addr_q;
        else if (br_e)      jump_tgt = br_tgt;
        else if (bp_held_q) jump_tgt = bp_addr_q;
        else if (bp_e)      jump_tgt = bp_tgt;
        else                jump     = 1'b0;
    end

    always_comb begin
        req_en_d  = 1'b1;
        pc_d      = pc_q;
        mask_d    = mask_q;
        br_held_d = br_held_q;
        br_addr_d = br_addr_q;
        bp_held_d = bp_held_q;
        bp_addr_d = bp_addr_q;
        fifo_d    = fifo_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;

        if (fire) begin
            pc_d      = jump ? (jump_tgt & ALIGN_MASK) : pc_q + 32'(BLK_BYTES);
            mask_d    = jump ? slot_mask(jump_tgt) : '1;
            br_held_d = 1'b0;
            bp_held_d = 1'b0;
        end else if (br_e) begin
            br_held_d = 1'b1;
            br_addr_d = br_tgt;
            bp_held_d = 1'b0;
        end else if (bp_take) begin
            bp_held_d = 1'b1;
            bp_addr_d = bp_tgt;
        end

        // Everything already in flight was fetched down the wrong path.
        if (redirect) begin
            for (int i = 0; i < MAX_OUT; i++) fifo_d[i].stale = 1'b1;
        end

        if (fire) begin
            fifo_d[wr_ptr_q] = '{pc: pc_q, mask: mask_q, stale: redirect};
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

        count_d = count_q + CNT_W'(fire) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            req_en_q  <= 1'b0;
            pc_q      <= RESET_PC & ALIGN_MASK;
            mask_q    <= slot_mask(RESET_PC);
            br_held_q <= 1'b0;
            br_addr_q <= '0;
            bp_held_q <= 1'b0;
            bp_addr_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            req_en_q  <= req_en_d;
            pc_q      <= pc_d;
            mask_q    <= mask_d;
            br_held_q <= br_held_d;
            br_addr_q <= br_addr_d;
            bp_held_q <= bp_held_d;
            bp_addr_q <= bp_addr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // NOTE: tag storage is not reset; the pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    data_ok_needs_tag: assert property (@(posedge clk) disable iff (!resetn)
        !(inst.inst_data_ok && fifo_empty));

endmodule

// File: tb/tb_if_fetch_gen.sv
// Randomised and directed bench for if_fetch_gen against a queue-based reference model.
module tb_if_fetch_gen;
    localparam logic [31:0] RST_PC = 32'hbfbf_fff8;

    logic        clk = 1'b0;
    logic        resetn, stall;
    logic [32:0] br_bus, bp_bus;
    logic        resp_valid;
    logic [31:0] resp_pc;
    logic [1:0]  resp_mask;
    logic [63:0] resp_inst;

    logic         resetn4, stall4;
    logic [32:0]  br_bus4, bp_bus4;
    logic         resp_valid4;
    logic [31:0]  resp_pc4;
    logic [3:0]   resp_mask4;
    logic [127:0] resp_inst4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    if_fetch_gen_if #(.FETCH_W(2)) bus ();
    if_fetch_gen_if #(.FETCH_W(4)) bus4 ();

    if_fetch_gen #(.FETCH_W(2), .RESET_PC(RST_PC), .MAX_OUT(4)) u_dut (
        .clk(clk), .resetn(resetn), .stall(stall), .br_bus(br_bus), .bp_bus(bp_bus),
        .inst(bus), .resp_valid(resp_valid), .resp_pc(resp_pc), .resp_mask(resp_mask),
        .resp_inst(resp_inst)
    );

    if_fetch_gen #(.FETCH_W(4), .RESET_PC(32'h1000_0000), .MAX_OUT(2)) u_dut4 (
        .clk(clk), .resetn(resetn4), .stall(stall4), .br_bus(br_bus4), .bp_bus(bp_bus4),
        .inst(bus4), .resp_valid(resp_valid4), .resp_pc(resp_pc4), .resp_mask(resp_mask4),
        .resp_inst(resp_inst4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one queue entry per outstanding request, in issue order.
    typedef struct {
        logic [31:0] pc;
        logic [1:0]  mask;
        bit          stale;
    } tag_t;

    tag_t        mq[$];
    bit          m_live = 0;
    bit          m_req_en;
    logic [31:0] m_pc;
    logic [1:0]  m_mask;
    bit          m_brh_v, m_bph_v;
    logic [31:0] m_brh_a, m_bph_a;

    function automatic logic [31:0] m_align(input logic [31:0] a);
        return a - (a % 32'd8);
    endfunction

    function automatic logic [1:0] m_smask(input logic [31:0] a);
        int s;
        s = int'((a % 32'd8) / 32'd4);
        return 2'(3 << s);
    endfunction

    task automatic drive_cycle(input bit rst, input bit stl, input logic [32:0] br,
                               input logic [32:0] bp, input bit aok, input bit dok);
        bit          dok_eff, exp_req, bp_ok, redir, fire, exp_rv, jump;
        logic [31:0] tgt;
        @(negedge clk);
        dok_eff          = dok && (mq.size() != 0);
        resetn           = rst;
        stall            = stl;
        br_bus           = br;
        bp_bus           = bp;
        bus.inst_addr_ok = aok;
        bus.inst_data_ok = dok_eff;
        bus.inst_rdata   = {$urandom, $urandom};
        #1;
        exp_req = m_req_en && !stl && (mq.size() < 4);
        bp_ok   = bp[32] && !br[32] && !m_brh_v;
        redir   = br[32] || bp_ok || m_brh_v || m_bph_v;
        fire    = exp_req && aok;
        exp_rv  = dok_eff && !mq[0].stale && !redir;
        if (m_live) begin
            check("inst_req", 64'(bus.inst_req), 64'(exp_req));
            check("inst_addr", 64'(bus.inst_addr), 64'(m_pc));
            check("resp_valid", 64'(resp_valid), 64'(exp_rv));
            check("resp_pc", 64'(resp_pc), exp_rv ? 64'(mq[0].pc) : 64'd0);
            check("resp_mask", 64'(resp_mask), exp_rv ? 64'(mq[0].mask) : 64'd0);
            check("resp_inst", resp_inst, bus.inst_rdata);
        end
        if (!rst) begin
            mq.delete();
            m_live   = 1;
            m_req_en = 0;
            m_pc     = m_align(RST_PC);
            m_mask   = m_smask(RST_PC);
            m_brh_v  = 0;
            m_bph_v  = 0;
            m_brh_a  = '0;
            m_bph_a  = '0;
        end else if (m_live) begin
            if (redir) foreach (mq[i]) mq[i].stale = 1;
            if (dok_eff) void'(mq.pop_front());
            if (fire) begin
                mq.push_back('{pc: m_pc, mask: m_mask, stale: redir});
                jump = 1;
                tgt  = '0;
                if (m_brh_v)     tgt = m_brh_a;
                else if (br[32]) tgt = br[31:0];
                else if (m_bph_v) tgt = m_bph_a;
                else if (bp[32]) tgt = bp[31:0];
                else             jump = 0;
                if (jump) begin
                    m_pc   = m_align(tgt);
                    m_mask = m_smask(tgt);
                end else begin
                    m_pc   = m_pc + 32'd8;
                    m_mask = 2'b11;
                end
                m_brh_v = 0;
                m_bph_v = 0;
            end else if (br[32]) begin
                m_brh_v = 1;
                m_brh_a = br[31:0];
                m_bph_v = 0;
            end else if (bp_ok) begin
                m_bph_v = 1;
                m_bph_a = bp[31:0];
            end
            m_req_en = 1;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 8 && mq.size() != 0; k++) drive_cycle(1, 0, '0, '0, 0, 1);
        check("drain_empty", 64'(mq.size()), 64'd0);
    endtask

    task automatic run_w4();
        resetn4 = 1'b0; stall4 = 1'b0; br_bus4 = '0; bp_bus4 = '0;
        bus4.inst_addr_ok = 1'b0; bus4.inst_data_ok = 1'b0; bus4.inst_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        check("w4_reset_req", 64'(bus4.inst_req), 64'd0);
        resetn4 = 1'b1;
        @(negedge clk);
        check("w4_req", 64'(bus4.inst_req), 64'd1);
        check("w4_reset_addr", 64'(bus4.inst_addr), 64'h1000_0000);
        br_bus4 = {1'b1, 32'h2000_001c};
        @(negedge clk);
        br_bus4 = '0;
        bus4.inst_addr_ok = 1'b1;
        #1 check("w4_held_addr", 64'(bus4.inst_addr), 64'h1000_0000);
        @(negedge clk);
        bus4.inst_data_ok = 1'b1;
        #1 check("w4_tgt_addr", 64'(bus4.inst_addr), 64'h2000_0010);
        check("w4_stale_drop", 64'(resp_valid4), 64'd0);
        @(negedge clk);
        bus4.inst_addr_ok = 1'b0;
        #1 check("w4_tgt_valid", 64'(resp_valid4), 64'd1);
        check("w4_tgt_pc", 64'(resp_pc4), 64'h2000_0010);
        check("w4_tgt_mask", 64'(resp_mask4), 64'b1000);
        @(negedge clk);
        bus4.inst_data_ok = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; stall = 1'b0; br_bus = '0; bp_bus = '0;
        bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = '0;

        run_w4();

        drive_cycle(0, 0, '0, '0, 0, 0);
        drive_cycle(0, 0, '0, '0, 1, 0);
        drive_cycle(1, 0, '0, '0, 1, 1);
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1, 0, '0, '0, 1, 1);
            check("seq_addr", 64'(bus.inst_addr), 64'(RST_PC + 32'(8 * i)));
        end

        drive_cycle(1, 0, {1'b1, 32'hbfc0_0104}, '0, 0, 1);
        drive_cycle(1, 0, '0, '0, 0, 1);
        drive_cycle(1, 0, '0, '0, 0, 1);
        check("br_hold_addr", 64'(bus.inst_addr), 64'(RST_PC + 32'd48));
        drive_cycle(1, 0, '0, '0, 1, 0);
        drive_cycle(1, 0, '0, '0, 1, 1);
        check("br_tgt_addr", 64'(bus.inst_addr), 64'hbfc0_0100);
        check("br_held_drop", 64'(resp_valid), 64'd0);
        drive_cycle(1, 0, '0, '0, 0, 1);
        check("br_tgt_mask", 64'(resp_mask), 64'b10);
        drain();

        drive_cycle(1, 0, {1'b1, 32'h0000_0200}, {1'b1, 32'h0000_0300}, 0, 1);
        drive_cycle(1, 0, '0, '0, 1, 1);
        drive_cycle(1, 0, '0, '0, 0, 1);
        check("br_over_bp", 64'(bus.inst_addr), 64'h0000_0200);
        drive_cycle(1, 0, {1'b1, 32'h0000_0400}, '0, 0, 1);
        drive_cycle(1, 0, '0, {1'b1, 32'h0000_0500}, 0, 1);
        drive_cycle(1, 0, '0, '0, 1, 1);
        drive_cycle(1, 0, '0, '0, 0, 1);
        check("bp_ignored", 64'(bus.inst_addr), 64'h0000_0400);
        drain();

        for (int i = 0; i < 6; i++) drive_cycle(1, 0, '0, '0, 1, 0);
        check("full_req", 64'(bus.inst_req), 64'd0);
        check("full_count", 64'(mq.size()), 64'd4);
        drive_cycle(1, 0, '0, '0, 1, 1);
        drive_cycle(1, 0, '0, '0, 1, 1);
        drive_cycle(1, 0, '0, '0, 1, 0);
        check("push_pop_count", 64'(mq.size()), 64'd4);
        drain();

        for (int i = 0; i < 3000; i++) begin
            drive_cycle($urandom_range(0, 99) != 0,
                        $urandom_range(0, 99) < 20,
                        ($urandom_range(0, 99) < 6)  ? {1'b1, 32'($urandom)} : 33'd0,
                        ($urandom_range(0, 99) < 10) ? {1'b1, 32'($urandom)} : 33'd0,
                        $urandom_range(0, 99) < 60,
                        $urandom_range(0, 99) < 50);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
